axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI3 single-beat responder backed by an internal word-addressed synchronous RAM.
- Serves as the memory/peripheral end of the CPU's AXI read (AR/R) and write (AW/W/B) channels in simulation and FPGA builds.
- Read and write paths are independent FSMs, so one read and one write can be in flight concurrently.
- One transaction per path at a time; multiple master IDs are serialised.

Parameters:
- ADDR_WIDTH, 16: byte-address bits decoded into RAM; depth = 2^(ADDR_WIDTH-2) words.
- BASE_ADDR, 32'h0000_0000: a hit requires addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH].
- LFSR_SEED, 16'hACE1: nonzero seed for the optional stall generator.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
arid  in  4  read ID
araddr  in  32  read byte address
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  4  echo of captured arid
rdata  out  32  read data
rresp  out  2  00 OKAY, 11 DECERR
rlast  out  1  constant 1
rvalid  out  1  R valid
rready  in  1  R ready
awid  in  4  write ID
awaddr  in  32  write byte address
awvalid  in  1  AW valid
awready  out  1  AW ready
wid  in  4  write-data ID
wdata  in  32  write data
wstrb  in  4  byte enables
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  4  echo of captured awid
bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
bvalid  out  1  B valid
bready  in  1  B ready

Behaviour:
- Reset and interface rules:
  - Reset is asynchronous, active-low. While rst_n=0 all outputs are 0 and both FSMs are in their IDLE states.
  - RAM contents are not reset and survive reset.
  - A transaction in flight when reset asserts is dropped; its response is never issued.
  - Single-beat only: len/size/burst are not ports and are treated as 0/word/INCR. wlast is not sampled.
  - Word index = addr[ADDR_WIDTH-1:2]. Bits [1:0] are ignored.
- Read FSM:
  - R_IDLE: arready=1. On arvalid&arready, capture arid and the address hit flag, and go to R_MEM.
  - R_MEM: RAM read issued; go to R_RESP.
  - R_RESP: rvalid=1 and rlast=1. rdata/rresp/rid are registered and held stable until rready. On rready go to R_IDLE.
  - A miss gives rresp=11 and rdata=0.
  - Latency: AR handshake at cycle T gives rvalid at T+2. Minimum spacing between AR handshakes is 3 cycles.
- Write FSM:
  - W_IDLE: awready=1, wready=1.
    - AW only: capture awid/addr, go to W_HAVE_A.
    - W only: capture wid/wdata/wstrb, go to W_HAVE_D.
    - Both in the same cycle: go to W_COMMIT.
  - W_HAVE_A: wready=1, awready=0. On W handshake go to W_COMMIT.
  - W_HAVE_D: awready=1, wready=0. On AW handshake go to W_COMMIT.
  - W_COMMIT: both readys 0.
    - Write the RAM byte-wise per wstrb only if hit and wid == awid.
    - bresp = DECERR on a miss; else SLVERR if wid != awid; else OKAY.
    - Go to W_RESP.
  - W_RESP: bvalid=1 and bid = captured awid, held until bready, then go to W_IDLE.
  - Latency: the second of the AW/W handshakes at T gives the RAM update at the end of T+1 and bvalid at T+2.
  - wstrb=0 with a hit: no bytes change, bresp=OKAY.
- Read/write interaction:
  - RAM is read-first. A read in R_MEM during the same cycle as a W_COMMIT to the same word returns the old data.
  - A read whose R_MEM cycle follows the commit returns the new data.
  - The master's same-word ordering guarantee covers this; the slave adds no further hazard logic.

Optional Feature:
AXI_SRAM_SLAVE_STALL_EN:
- Defined: adds a 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to LFSR_SEED, advancing every cycle.
  - lfsr[0]=1 forces arready=0.
  - lfsr[1]=1 forces awready=0 and wready=0.
  - lfsr[2]=1 holds R_MEM→R_RESP and W_COMMIT→W_RESP for that cycle, delaying only the first assertion of rvalid/bvalid.
  - Once rvalid/bvalid is asserted it is held until handshake.
- Undefined: no LFSR logic; fixed latencies as above.

Test Plan:
1. AW+W same cycle: awid=2, addr 0x10, wdata 0xDEADBEEF, wstrb F -> bvalid at T+2, bid=2, bresp=00. Then AR id 0, addr 0x10 -> rvalid at T+2, rdata=0xDEADBEEF, rid=0, rlast=1, rresp=00.
2. W (wid=1, wdata 0x0000AB00, wstrb 0010) three cycles before AW (awid=1, addr 0x12) -> awready stays 1, wready 0 while waiting, bresp=00. Read of 0x10 -> 0xDEADABEF.
3. araddr 0x1FFF0000 with BASE_ADDR=0 -> rresp=11, rdata=0. Write to the same address -> bresp=11; a read of 0x10 still returns 0xDEADABEF.
4. rready and bready held low 5 cycles during a concurrent read (0x10) and write (0x20) -> rvalid/rdata/rid and bvalid/bid/bresp stable throughout; both complete after the readys rise.
5. awid=3, wid=1, addr 0x10 -> bresp=10, bid=3; 0x10 is unchanged.
6. rst_n driven low during W_RESP -> bvalid=0 immediately. After release, arready/awready/wready=1 on the next edge, and 0x10 still reads 0xDEADABEF.

Source files
------------

// File: rtl/axi_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave
// Description : AXI3 single-beat slave backed by a word-addressed synchronous
//               RAM. Independent read and write FSMs allow one read and one
//               write in flight at the same time.
//               Optional random back-pressure: define AXI_SRAM_SLAVE_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int unsigned IDX_W = ADDR_WIDTH - 2;
   localparam int unsigned DEPTH = 2 ** IDX_W;

   localparam logic [1:0] R_IDLE   = 2'd0;
   localparam logic [1:0] R_MEM    = 2'd1;
   localparam logic [1:0] R_RESP   = 2'd2;

   localparam logic [2:0] W_IDLE   = 3'd0;
   localparam logic [2:0] W_HAVE_A = 3'd1;
   localparam logic [2:0] W_HAVE_D = 3'd2;
   localparam logic [2:0] W_COMMIT = 3'd3;
   localparam logic [2:0] W_RESP   = 3'd4;

   logic [31:0]      mem [DEPTH];
   logic             run;
   logic             stall_ar, stall_w, stall_resp;

   logic [1:0]       r_state, r_next;
   logic [3:0]       rd_id;
   logic [IDX_W-1:0] rd_idx;
   logic             rd_hit;
   logic [31:0]      rd_word;
   logic             ar_hit;

   logic [2:0]       w_state, w_next;
   logic [3:0]       wr_awid, wr_wid;
   logic [IDX_W-1:0] wr_idx;
   logic             wr_hit;
   logic [31:0]      wr_data;
   logic [3:0]       wr_strb;
   logic [1:0]       wr_resp;
   logic             aw_hit, aw_hs, w_hs;

   // Address bits [1:0] carry no information for word accesses
   logic             unused_addr_bits;
   assign unused_addr_bits = ^{araddr[1:0], awaddr[1:0]};

`ifdef AXI_SRAM_SLAVE_STALL_EN
   logic [15:0] lfsr;

   // Free-running Fibonacci LFSR (taps 16,14,13,11) drives pseudo-random stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= LFSR_SEED;
      else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign stall_ar   = lfsr[0];
   assign stall_w    = lfsr[1];
   assign stall_resp = lfsr[2];
`else
   logic unused_seed;
   assign unused_seed = ^LFSR_SEED;
   assign stall_ar    = 1'b0;
   assign stall_w     = 1'b0;
   assign stall_resp  = 1'b0;
`endif

   // Readys stay low through reset and rise on the first edge after release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run <= 1'b0;
      else        run <= 1'b1;
   end

   assign ar_hit = (araddr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
   assign aw_hit = (awaddr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);

   // ---------------------------------------------------------------- read path
   // Read FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= R_IDLE;
      else        r_state <= r_next;
   end

   // Read FSM next-state logic
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (arvalid && arready) r_next = R_MEM;
         R_MEM:   if (!stall_resp)        r_next = R_RESP;
         R_RESP:  if (rready)             r_next = R_IDLE;
         default:                         r_next = R_IDLE;
      endcase
   end

   // Read FSM outputs
   always_comb begin
      arready = run && (r_state == R_IDLE) && !stall_ar;
      rvalid  = (r_state == R_RESP);
   end

   // Capture the read request on the AR handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_id  <= '0;
         rd_idx <= '0;
         rd_hit <= 1'b0;
      end else if (arvalid && arready) begin
         rd_id  <= arid;
         rd_idx <= araddr[ADDR_WIDTH-1:2];
         rd_hit <= ar_hit;
      end
   end

   assign rid   = rd_id;
   assign rdata = (rvalid && rd_hit) ? rd_word : 32'h0;
   assign rresp = (rvalid && !rd_hit) ? 2'b11 : 2'b00;
   assign rlast = run;

   // --------------------------------------------------------------- write path
   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;

   // Write FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) w_state <= W_IDLE;
      else        w_state <= w_next;
   end

   // Write FSM next-state logic
   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) w_next = W_COMMIT;
            else if (aw_hs)    w_next = W_HAVE_A;
            else if (w_hs)     w_next = W_HAVE_D;
         end
         W_HAVE_A: if (w_hs)        w_next = W_COMMIT;
         W_HAVE_D: if (aw_hs)       w_next = W_COMMIT;
         W_COMMIT: if (!stall_resp) w_next = W_RESP;
         W_RESP:   if (bready)      w_next = W_IDLE;
         default:                   w_next = W_IDLE;
      endcase
   end

   // Write FSM outputs
   always_comb begin
      awready = run && !stall_w && ((w_state == W_IDLE) || (w_state == W_HAVE_D));
      wready  = run && !stall_w && ((w_state == W_IDLE) || (w_state == W_HAVE_A));
      bvalid  = (w_state == W_RESP);
   end

   // Capture address and data beats independently; resolve the response at commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_awid <= '0;
         wr_idx  <= '0;
         wr_hit  <= 1'b0;
         wr_wid  <= '0;
         wr_data <= '0;
         wr_strb <= '0;
         wr_resp <= 2'b00;
      end else begin
         if (aw_hs) begin
            wr_awid <= awid;
            wr_idx  <= awaddr[ADDR_WIDTH-1:2];
            wr_hit  <= aw_hit;
         end
         if (w_hs) begin
            wr_wid  <= wid;
            wr_data <= wdata;
            wr_strb <= wstrb;
         end
         if (w_state == W_COMMIT) begin
            if (!wr_hit)                wr_resp <= 2'b11;
            else if (wr_wid != wr_awid) wr_resp <= 2'b10;
            else                        wr_resp <= 2'b00;
         end
      end
   end

   assign bid   = wr_awid;
   assign bresp = bvalid ? wr_resp : 2'b00;

   // --------------------------------------------------------------------- RAM
   // Read-first RAM: a same-cycle read and commit to one word returns old data
   always_ff @(posedge clk) begin
      if (r_state == R_MEM) rd_word <= mem[rd_idx];
      if ((w_state == W_COMMIT) && wr_hit && (wr_wid == wr_awid)) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_sram_slave
// Description : Self-checking bench for axi_sram_slave: directed vector table,
//               concurrent back-pressure and reset sequences, and randomized
//               traffic against a word-array memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  arid, rid, awid, wid, bid;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [1:0]  rresp, bresp;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;

   always #5 clk = ~clk;

   axi_sram_slave dut (
      .clk(clk), .rst_n(rst_n),
      .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // lead > 0: W beat leads AW by lead cycles; lead < 0: AW leads W.
   task automatic write_txn(input logic [3:0] ida, input logic [3:0] idw,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead, input int hold,
                            output logic [1:0] resp, output logic [3:0] id_o, output int lat);
      int cyc, a_start, w_start;
      bit a_done, w_done, ah, wh;
      logic [6:0] snap;
      a_start = (lead < 0) ? 0 : lead;
      w_start = (lead < 0) ? -lead : 0;
      a_done = 0; w_done = 0; cyc = 0;
      @(negedge clk);
      awid = ida; awaddr = addr; wid = idw; wdata = data; wstrb = strb;
      awvalid = (a_start == 0);
      wvalid  = (w_start == 0);
      while (!(a_done && w_done) && cyc < 100) begin
         ah = awvalid && awready;
         wh = wvalid && wready;
         @(negedge clk);
         cyc++;
         if (ah) begin a_done = 1; awvalid = 0; end
         if (wh) begin w_done = 1; wvalid = 0; end
         if (!a_done && cyc >= a_start) awvalid = 1;
         if (!w_done && cyc >= w_start) wvalid = 1;
         if (a_done != w_done)
            chk("wait_readys", {awready, wready}, a_done ? 2'b01 : 2'b10);
      end
      if (cyc >= 100) chk("aw_w_handshake_timeout", 1, 0);
      awvalid = 0; wvalid = 0;
      lat = 0;
      while (!bvalid && lat < 50) begin @(negedge clk); lat++; end
      resp = bresp; id_o = bid;
      snap = {bvalid, bid, bresp};
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("b_stable", {bvalid, bid, bresp}, snap);
      end
      bready = 1;
      @(negedge clk);
      bready = 0;
      chk("b_drop", bvalid, 0);
   endtask

   task automatic read_txn(input logic [3:0] id, input logic [31:0] addr, input int hold,
                           output logic [31:0] d, output logic [1:0] resp,
                           output logic [3:0] id_o, output int lat, output logic last);
      int cyc;
      logic [38:0] snap;
      cyc = 0;
      @(negedge clk);
      arvalid = 1; arid = id; araddr = addr;
      while (!arready && cyc < 100) begin @(negedge clk); cyc++; end
      if (cyc >= 100) chk("ar_handshake_timeout", 1, 0);
      @(negedge clk);
      arvalid = 0;
      lat = 0;
      while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
      d = rdata; resp = rresp; id_o = rid; last = rlast;
      snap = {rvalid, rid, rdata, rresp};
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("r_stable", {rvalid, rid, rdata, rresp}, snap);
      end
      rready = 1;
      @(negedge clk);
      rready = 0;
      chk("r_drop", rvalid, 0);
   endtask

   typedef struct {
      bit          wr;
      logic [3:0]  ida;
      logic [3:0]  idw;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          lead;
      logic [1:0]  eresp;
      logic [3:0]  eid;
      logic [31:0] edata;
   } vec_t;

   // Reference memory model: word index -> contents
   logic [31:0] model [int];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        v [11];
      logic [31:0] d, d2, data, addr, cur;
      logic [1:0]  resp, resp2;
      logic [3:0]  id, id2, ida, idw, strb;
      logic        last;
      int          lat, lat2, lead, hold, k;
      bit          miss;
      logic [1:0]  eresp;

      arid = 0; araddr = 0; arvalid = 0; rready = 0;
      awid = 0; awaddr = 0; awvalid = 0; wid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;

      // Reset state
      rst_n = 0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {arready, awready, wready, rvalid, bvalid, rlast, rid, rdata,
                            rresp, bid, bresp}, 0);
      rst_n = 1;
      @(negedge clk);
      chk("readys_after_reset", {arready, awready, wready}, 3'b111);

      //        wr ida   idw   addr           data           strb  lead eresp  eid   edata
      v[0]  = '{1, 4'd2, 4'd2, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 0, 2'b00, 4'd2, 32'h0};
      v[1]  = '{0, 4'd0, 4'd0, 32'h0000_0010, 32'h0,        4'h0, 0, 2'b00, 4'd0, 32'hDEADBEEF};
      v[2]  = '{1, 4'd1, 4'd1, 32'h0000_0012, 32'h0000AB00, 4'h2, 3, 2'b00, 4'd1, 32'h0};
      v[3]  = '{0, 4'd0, 4'd0, 32'h0000_0010, 32'h0,        4'h0, 0, 2'b00, 4'd0, 32'hDEADABEF};
      v[4]  = '{0, 4'd5, 4'd0, 32'h1FFF_0000, 32'h0,        4'h0, 0, 2'b11, 4'd5, 32'h0};
      v[5]  = '{1, 4'd4, 4'd4, 32'h1FFF_0000, 32'h12345678, 4'hF, 0, 2'b11, 4'd4, 32'h0};
      v[6]  = '{0, 4'd0, 4'd0, 32'h0000_0010, 32'h0,        4'h0, 0, 2'b00, 4'd0, 32'hDEADABEF};
      v[7]  = '{1, 4'd3, 4'd1, 32'h0000_0010, 32'hFFFFFFFF, 4'hF, 0, 2'b10, 4'd3, 32'h0};
      v[8]  = '{0, 4'd6, 4'd0, 32'h0000_0010, 32'h0,        4'h0, 0, 2'b00, 4'd6, 32'hDEADABEF};
      v[9]  = '{1, 4'd7, 4'd7, 32'h0000_0010, 32'h00000000, 4'h0, -2, 2'b00, 4'd7, 32'h0};
      v[10] = '{0, 4'd0, 4'd0, 32'h0000_0013, 32'h0,        4'h0, 0, 2'b00, 4'd0, 32'hDEADABEF};

      foreach (v[i]) begin
         if (v[i].wr) begin
            write_txn(v[i].ida, v[i].idw, v[i].addr, v[i].data, v[i].strb, v[i].lead, 0,
                      resp, id, lat);
            chk($sformatf("vec%0d_bresp", i), resp, v[i].eresp);
            chk($sformatf("vec%0d_bid", i), id, v[i].eid);
            chk($sformatf("vec%0d_b_latency", i), lat, 1);
         end else begin
            read_txn(v[i].ida, v[i].addr, 0, d, resp, id, lat, last);
            chk($sformatf("vec%0d_rresp", i), resp, v[i].eresp);
            chk($sformatf("vec%0d_rid", i), id, v[i].eid);
            chk($sformatf("vec%0d_rdata", i), d, v[i].edata);
            chk($sformatf("vec%0d_rlast", i), last, 1);
            chk($sformatf("vec%0d_r_latency", i), lat, 1);
         end
      end

      // Concurrent read and write with both response channels back-pressured
      fork
         read_txn(4'd8, 32'h10, 5, d, resp, id, lat, last);
         write_txn(4'd9, 4'd9, 32'h20, 32'hCAFEF00D, 4'hF, 0, 5, resp2, id2, lat2);
      join
      chk("conc_rdata", d, 32'hDEADABEF);
      chk("conc_rid", id, 4'd8);
      chk("conc_rresp", resp, 2'b00);
      chk("conc_bresp", resp2, 2'b00);
      chk("conc_bid", id2, 4'd9);
      read_txn(4'd0, 32'h20, 0, d, resp, id, lat, last);
      chk("conc_write_landed", d, 32'hCAFEF00D);

      // Randomized traffic against the memory model (window 0x100..0x13F)
      for (int j = 0; j < 16; j++) begin
         data = $urandom;
         write_txn(4'd1, 4'd1, 32'h100 + 4 * j, data, 4'hF, 0, 0, resp, id, lat);
         model[64 + j] = data;
      end
      for (int it = 0; it < 60; it++) begin
         miss = ($urandom_range(0, 7) == 0);
         k    = int'($urandom_range(0, 15));
         addr = (miss ? 32'h8000_0100 : 32'h0000_0100) + 4 * k + $urandom_range(0, 3);
         hold = int'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            ida  = 4'($urandom);
            idw  = ($urandom_range(0, 3) == 0) ? (ida ^ 4'h5) : ida;
            data = $urandom;
            strb = 4'($urandom);
            lead = int'($urandom_range(0, 6)) - 3;
            write_txn(ida, idw, addr, data, strb, lead, hold, resp, id, lat);
            if (miss)             eresp = 2'b11;
            else if (ida != idw)  eresp = 2'b10;
            else                  eresp = 2'b00;
            if (eresp == 2'b00) begin
               cur = model[64 + k];
               for (int b = 0; b < 4; b++)
                  if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
               model[64 + k] = cur;
            end
            chk("rand_bresp", resp, eresp);
            chk("rand_bid", id, ida);
            chk("rand_b_latency", lat, 1);
         end else begin
            ida = 4'($urandom);
            read_txn(ida, addr, hold, d, resp, id, lat, last);
            chk("rand_rdata", d, miss ? 32'h0 : model[64 + k]);
            chk("rand_rresp", resp, miss ? 2'b11 : 2'b00);
            chk("rand_rid", id, ida);
            chk("rand_r_latency", lat, 1);
         end
      end

      // Reset asserted while a write response is pending
      @(negedge clk);
      awvalid = 1; awid = 4'd9; awaddr = 32'h40; wvalid = 1; wid = 4'd9;
      wdata = 32'h0BADF00D; wstrb = 4'hF;
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      lat = 0;
      while (!bvalid && lat < 50) begin @(negedge clk); lat++; end
      chk("rst_pre_bvalid", bvalid, 1);
      rst_n = 0;
      #1;
      chk("rst_bvalid_drop", bvalid, 0);
      chk("rst_all_outputs", {arready, awready, wready, rvalid, bvalid, rlast, rid, rdata,
                              rresp, bid, bresp}, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("rst_release_readys", {arready, awready, wready}, 3'b111);
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_stale_b", bvalid, 0);
      end
      read_txn(4'd0, 32'h10, 0, d, resp, id, lat, last);
      chk("rst_ram_survives", d, 32'hDEADABEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
